// File: rtl/hs_tx_ctrl_if.sv
// rtl/hs_tx_ctrl_if.sv - Requester and shift-register handshake bundle for hs_tx_ctrl
interface hs_tx_ctrl_if;
    logic       tx_enable;
    logic [1:0] req;
    logic [9:0] data0;
    logic [9:0] data1;
    logic [1:0] gnt;
    logic       sr_load_enable;
    logic       sr_shift_enable;
    logic [9:0] sr_parallel_in;
    logic       busy;
    logic       word_done;

    modport master (
        output tx_enable, req, data0, data1,
        input  gnt, sr_load_enable, sr_shift_enable, sr_parallel_in, busy, word_done
    );

    modport slave (
        input  tx_enable, req, data0, data1,
        output gnt, sr_load_enable, sr_shift_enable, sr_parallel_in, busy, word_done
    );
endinterface

// File: rtl/hs_tx_ctrl.sv
// rtl/hs_tx_ctrl.sv - Round-robin two-port transmit sequencer driving the hs_sr shift register
// Optional inter-word idle gap is enabled by defining HS_TX_GAP_EN.
module hs_tx_ctrl #(
    parameter int unsigned BIT_PERIOD = 4,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic         clk,
    input  logic         n_rst,
    hs_tx_ctrl_if.slave  bus
);

    localparam int unsigned CW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BIT_PERIOD - 1);

    if (BIT_PERIOD == 0 || GAP_CYCLES == 0) begin : g_bad_params
        $error("hs_tx_ctrl: BIT_PERIOD and GAP_CYCLES must be >= 1");
    end

`ifdef HS_TX_GAP_EN
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYCLES - 1);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;
    logic [GW-1:0] gap_cnt_q;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;
`endif

    state_t        state_q;
    logic          last_q;
    logic [CW-1:0] clk_cnt_q;
    logic [3:0]    bit_cnt_q;
    logic [1:0]    gnt_q;
    logic          load_q;
    logic          shift_q;
    logic [9:0]    data_q;
    logic          busy_q;
    logic          done_q;

    logic          win_d;
    logic          pulse_now;
    logic [CW-1:0] clk_cnt_d;
    logic [3:0]    bit_cnt_d;

    // Both pending: serve the port that was not served last.
    assign win_d     = (bus.req == 2'b11) ? ~last_q : bus.req[1];
    assign pulse_now = (clk_cnt_q == CNT_MAX);
    assign clk_cnt_d = pulse_now ? '0 : clk_cnt_q + 1'b1;
    assign bit_cnt_d = pulse_now ? bit_cnt_q + 4'd1 : bit_cnt_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= S_IDLE;
            last_q    <= 1'b1;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            gnt_q     <= '0;
            load_q    <= 1'b0;
            shift_q   <= 1'b0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef HS_TX_GAP_EN
            gap_cnt_q <= '0;
`endif
        end else begin
            gnt_q   <= '0;
            load_q  <= 1'b0;
            shift_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.tx_enable && (bus.req != 2'b00)) begin
                        state_q <= S_LOAD;
                        last_q  <= win_d;
                        gnt_q   <= win_d ? 2'b10 : 2'b01;
                        load_q  <= 1'b1;
                        data_q  <= win_d ? bus.data1 : bus.data0;
                        busy_q  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    state_q   <= S_SHIFT;
                    clk_cnt_q <= '0;
                    bit_cnt_q <= '0;
                    shift_q   <= (CNT_MAX == '0);
                end
                S_SHIFT: begin
                    clk_cnt_q <= clk_cnt_d;
                    bit_cnt_q <= bit_cnt_d;
                    if (pulse_now && (bit_cnt_q == 4'd9)) begin
`ifdef HS_TX_GAP_EN
                        state_q   <= S_GAP;
                        gap_cnt_q <= '0;
`else
                        state_q   <= S_IDLE;
                        busy_q    <= 1'b0;
`endif
                    end else begin
                        // Outputs are registered, so decide next cycle's pulse from next-state counters.
                        shift_q <= (clk_cnt_d == CNT_MAX);
                        done_q  <= (clk_cnt_d == CNT_MAX) && (bit_cnt_d == 4'd9);
                    end
                end
`ifdef HS_TX_GAP_EN
                S_GAP: begin
                    if (gap_cnt_q == GAP_MAX) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt             = gnt_q;
    assign bus.sr_load_enable  = load_q;
    assign bus.sr_shift_enable = shift_q;
    assign bus.sr_parallel_in  = data_q;
    assign bus.busy            = busy_q;
    assign bus.word_done       = done_q;

endmodule

// File: tb/tb_hs_tx_ctrl.sv
// tb/tb_hs_tx_ctrl.sv - Self-checking bench for hs_tx_ctrl with a cycle-timeline reference model
`timescale 1ns/1ps
module tb_hs_tx_ctrl;

    localparam int BP = 4;
`ifdef HS_TX_GAP_EN
    localparam int GAP = 2;
`else
    localparam int GAP = 0;
`endif
    localparam int SPACING = 10 * BP + GAP + 2;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic last_m;

    hs_tx_ctrl_if bus4 ();
    hs_tx_ctrl_if bus1 ();

    hs_tx_ctrl #(.BIT_PERIOD(BP), .GAP_CYCLES(2)) dut4 (.clk(clk), .n_rst(n_rst), .bus(bus4));
    hs_tx_ctrl #(.BIT_PERIOD(1),  .GAP_CYCLES(2)) dut1 (.clk(clk), .n_rst(n_rst), .bus(bus1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        n_checks++;
        assert (obs === expd) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expd);
        end
    endtask

    function automatic logic pick(input logic [1:0] r);
        return (r == 2'b11) ? ~last_m : r[1];
    endfunction

    task automatic chk_zero4(input string tag);
        chk({tag, "_gnt"},   32'(bus4.gnt), 32'd0);
        chk({tag, "_load"},  32'(bus4.sr_load_enable), 32'd0);
        chk({tag, "_shift"}, 32'(bus4.sr_shift_enable), 32'd0);
        chk({tag, "_data"},  32'(bus4.sr_parallel_in), 32'd0);
        chk({tag, "_busy"},  32'(bus4.busy), 32'd0);
        chk({tag, "_done"},  32'(bus4.word_done), 32'd0);
    endtask

    // One word on the BIT_PERIOD=4 instance, checked cycle by cycle against the expected timeline.
    task automatic run_word(input logic exp_port, input logic [9:0] exp_data, input bit drop,
                            input int late_k, input int txoff_k, input int rst_pulses,
                            output int load_cyc);
        int waited;
        waited = 0;
        load_cyc = -1;
        while (bus4.sr_load_enable !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (bus4.sr_load_enable !== 1'b1) begin
            chk("load_timeout", 32'(bus4.sr_load_enable), 32'd1);
            return;
        end
        load_cyc = cyc;
        chk("gnt", 32'(bus4.gnt), exp_port ? 32'd2 : 32'd1);
        chk("load_data", 32'(bus4.sr_parallel_in), 32'(exp_data));
        chk("load_busy", 32'(bus4.busy), 32'd1);
        chk("load_noshift", 32'(bus4.sr_shift_enable), 32'd0);
        last_m = exp_port;
        if (drop) bus4.req[exp_port] = 1'b0;
        for (int k = 1; k <= 10 * BP; k++) begin
            @(negedge clk);
            chk("shift", 32'(bus4.sr_shift_enable), 32'(k % BP == 0));
            chk("done", 32'(bus4.word_done), 32'(k == 10 * BP));
            chk("no_load", 32'(bus4.sr_load_enable), 32'd0);
            chk("no_gnt", 32'(bus4.gnt), 32'd0);
            chk("busy", 32'(bus4.busy), 32'd1);
            chk("hold_data", 32'(bus4.sr_parallel_in), 32'(exp_data));
            if (k == late_k) bus4.req[1] = 1'b1;
            if (k == txoff_k) bus4.tx_enable = 1'b0;
            if (k == rst_pulses * BP) begin
                #2 n_rst = 1'b0;
                #1 chk_zero4("rst_mid");
                @(negedge clk);
                n_rst = 1'b1;
                last_m = 1'b1;
                return;
            end
        end
        for (int g = 1; g <= GAP; g++) begin
            @(negedge clk);
            chk("gap_busy", 32'(bus4.busy), 32'd1);
            chk("gap_load", 32'(bus4.sr_load_enable), 32'd0);
            chk("gap_shift", 32'(bus4.sr_shift_enable), 32'd0);
        end
        @(negedge clk);
        chk("idle_busy", 32'(bus4.busy), 32'd0);
    endtask

    initial begin
        int         lc;
        int         prev;
        int         waited;
        logic       w;
        logic [1:0] newr;
        logic [9:0] d0;
        logic [9:0] d1;

        bus4.tx_enable = 1'b1; bus4.req = 2'b00; bus4.data0 = '0; bus4.data1 = '0;
        bus1.tx_enable = 1'b1; bus1.req = 2'b00; bus1.data0 = '0; bus1.data1 = '0;
        last_m = 1'b1;
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero4("reset");
        chk("reset_busy1", 32'(bus1.busy), 32'd0);
        n_rst = 1'b1;
        @(negedge clk);

        // Single word from port 0.
        bus4.data0 = 10'h3CF;
        bus4.req = 2'b01;
        run_word(1'b0, 10'h3CF, 1'b1, 0, 0, 0, lc);

        // Random request patterns; a pending port keeps its request and data until granted.
        for (int i = 0; i < 8; i++) begin
            newr = 2'($urandom_range(1, 3));
            if (newr[0] && !bus4.req[0]) bus4.data0 = 10'($urandom);
            if (newr[1] && !bus4.req[1]) bus4.data1 = 10'($urandom);
            bus4.req = bus4.req | newr;
            w = pick(bus4.req);
            run_word(w, w ? bus4.data1 : bus4.data0, 1'b1, 0, 0, 0, lc);
        end
        if (bus4.req != 2'b00) begin
            w = pick(bus4.req);
            run_word(w, w ? bus4.data1 : bus4.data0, 1'b1, 0, 0, 0, lc);
        end

        // Reset after the third pulse, then round-robin restarts at port 0.
        bus4.data0 = 10'h3CF;
        bus4.data1 = 10'h07C;
        bus4.req = 2'b11;
        w = pick(bus4.req);
        run_word(w, w ? 10'h07C : 10'h3CF, 1'b0, 0, 0, 3, lc);
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            run_word(1'(i % 2), (i % 2) ? 10'h07C : 10'h3CF, 1'b0, 0, 0, 0, lc);
            if (i > 0) chk("rr_spacing", 32'(lc - prev), 32'(SPACING));
            prev = lc;
        end
        bus4.req = 2'b00;

        // Late request mid-word and tx_enable dropped during SHIFT.
        d0 = 10'($urandom);
        d1 = 10'($urandom);
        bus4.data0 = d0;
        bus4.data1 = d1;
        bus4.req = 2'b01;
        @(negedge clk);
        run_word(1'b0, d0, 1'b1, 2 * BP + 1, 5 * BP, 0, lc);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("txoff_load", 32'(bus4.sr_load_enable), 32'd0);
            chk("txoff_busy", 32'(bus4.busy), 32'd0);
            chk("txoff_gnt", 32'(bus4.gnt), 32'd0);
        end
        bus4.tx_enable = 1'b1;
        run_word(1'b1, d1, 1'b1, 0, 0, 0, lc);

        // BIT_PERIOD=1 instance: ten contiguous pulses right after LOAD.
        d0 = 10'($urandom);
        bus1.data0 = d0;
        bus1.data1 = 10'($urandom);
        bus1.req = 2'b11;
        waited = 0;
        while (bus1.sr_load_enable !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("bp1_load", 32'(bus1.sr_load_enable), 32'd1);
        chk("bp1_gnt", 32'(bus1.gnt), 32'd1);
        chk("bp1_data", 32'(bus1.sr_parallel_in), 32'(d0));
        chk("bp1_overlap0", 32'(bus1.sr_load_enable & bus1.sr_shift_enable), 32'd0);
        bus1.req = 2'b00;
        for (int k = 1; k <= 11 + GAP; k++) begin
            @(negedge clk);
            chk("bp1_shift", 32'(bus1.sr_shift_enable), 32'(k <= 10));
            chk("bp1_done", 32'(bus1.word_done), 32'(k == 10));
            chk("bp1_busy", 32'(bus1.busy), 32'(k <= 10 + GAP));
            chk("bp1_overlap", 32'(bus1.sr_load_enable & bus1.sr_shift_enable), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hs_tx_ctrl.md
# hs_tx_ctrl

Transmit sequencer and two-port arbiter for the 10-bit handshake shift register (`hs_sr`). Two requesters each offer a 10-bit word. The block picks one round-robin, presents the word on `sr_parallel_in`, and pulses `sr_load_enable`. It then issues one `sr_shift_enable` pulse per bit period until all 10 bits have been shifted out. It sits directly above `hs_sr` in the transmit path, and `hs_sr` needs no other control.

## Interface
- `BIT_PERIOD`, default 4: clock cycles each bit is held on `serial_out`. Legal range is ≥1.
- `GAP_CYCLES`, default 2: idle cycles inserted between words. Used only when `HS_TX_GAP_EN` is defined; legal range is ≥1.
- `clk` input, 1 bit: the single clock. Rising edge.
- `n_rst` input, 1 bit: asynchronous reset, active low.
- `tx_enable` input, 1 bit: while low, no new word is started. A word already in progress always completes.
- `req` input, 2 bits: `req[i]` means requester i has a word pending. It must stay high, with its data stable, until `gnt[i]`.
- `data0` input, 10 bits: word from requester 0.
- `data1` input, 10 bits: word from requester 1.
- `gnt` output, 2 bits: one-cycle, one-hot acknowledge that the word was accepted.
- `sr_load_enable` output, 1 bit: connects to `hs_sr.load_enable`.
- `sr_shift_enable` output, 1 bit: connects to `hs_sr.shift_enable`.
- `sr_parallel_in` output, 10 bits: connects to `hs_sr.parallel_in`. Registered.
- `busy` output, 1 bit: high in every state except IDLE.
- `word_done` output, 1 bit: one-cycle pulse, coincident with the 10th shift pulse.

## Operation
- FSM states are IDLE, LOAD, SHIFT, and GAP. GAP exists only when `HS_TX_GAP_EN` is defined.
- **IDLE**
  - Both SR enables are low.
  - If `tx_enable` is high and `req` is nonzero, the arbiter picks a winner.
  - At the clock edge the block latches the winner's data into `sr_parallel_in`, records the winner, and moves to LOAD.
- **Arbitration**
  - A priority pointer `last` holds the most recently served port. It resets to 1, so port 0 wins first.
  - If only one request is present, that port wins.
  - If both are present, the port other than `last` wins.
  - `last` updates on the IDLE→LOAD transition.
- **LOAD**, exactly one cycle:
  - `sr_load_enable` = 1.
  - `gnt[winner]` = 1.
  - Bit counter and clock counter are cleared.
  - Next state is SHIFT.
- **SHIFT**
  - The clock counter runs 0..`BIT_PERIOD`-1 and wraps.
  - When the clock counter equals `BIT_PERIOD`-1, `sr_shift_enable` = 1 and the bit counter increments.
  - On the pulse where the bit counter equals 9 (the 10th pulse), `word_done` = 1.
  - After that pulse, the next state is IDLE, or GAP if `HS_TX_GAP_EN` is defined.
- **GAP**: see Configuration.
- `sr_parallel_in` holds its value until the next capture. `sr_load_enable` and `sr_shift_enable` are never high in the same cycle.
- `req` changes during LOAD, SHIFT, or GAP are ignored. Arbitration happens only in IDLE.
- Dropping `tx_enable` mid-word does not stop the word. It only blocks the next IDLE→LOAD transition.
- Counter widths are `$clog2(BIT_PERIOD)` (minimum 1 bit) and 4 bits for the bit counter.
- With `BIT_PERIOD`=1, `sr_shift_enable` is high on every SHIFT cycle.

## Timing
- **Reset**: asserting `n_rst` low takes effect immediately, including mid-word. Every output goes to 0:
  - `gnt`=0, `sr_load_enable`=0, `sr_shift_enable`=0.
  - `sr_parallel_in`=10'h000, `busy`=0, `word_done`=0.
  - State = IDLE, counters = 0, `last` = 1.
- **Request to load**: `req` sampled high in IDLE at edge k gives LOAD (`gnt`, `sr_load_enable`) in cycle k+1.
- **Shift pulses**: taking LOAD as cycle L, the pulses fall in cycles L+`BIT_PERIOD`+n·`BIT_PERIOD` for n=0..9.
- **End of word**: the last pulse, with `word_done`, is in cycle L+10·`BIT_PERIOD`.
- **Back-to-back** (macro off): the next LOAD is no earlier than L+10·`BIT_PERIOD`+2, because one IDLE cycle is needed for arbitration.
- **Word occupancy**: `busy` is high from L through L+10·`BIT_PERIOD` inclusive.

## Configuration
- Macro: `HS_TX_GAP_EN`.
- **Defined**:
  - After `word_done`, the FSM enters GAP for exactly `GAP_CYCLES` cycles.
  - During GAP, both enables are low and `busy` = 1.
  - After GAP, the FSM returns to IDLE.
  - The minimum LOAD-to-LOAD spacing becomes 10·`BIT_PERIOD`+`GAP_CYCLES`+2.
- **Undefined**: the GAP state, its counter, and `GAP_CYCLES` usage are removed. The FSM goes directly from SHIFT to IDLE.

## Test plan
- **Reset mid-word** (`BIT_PERIOD`=4): pull `n_rst` low during SHIFT after the 3rd shift pulse.
  - Immediately: all outputs are 0 and `busy`=0.
  - After release: with `req`=2'b11, port 0 is granted first.
- **Single word**: `req`=2'b01, `data0`=10'b1111001111, LOAD in cycle L.
  - `gnt`=01 and `sr_load_enable` in cycle L.
  - `sr_parallel_in`=10'h3CF from L onward.
  - Shift pulses at L+4, L+8, …, L+40.
  - `word_done` at L+40, `busy` low at L+41.
- **Round-robin**: hold `req`=2'b11 with `data0`=10'h3CF and `data1`=10'h07C for 4 words.
  - Grant order is 0, 1, 0, 1.
  - `sr_parallel_in` alternates 3CF, 07C.
  - LOAD cycles are spaced exactly 42 cycles apart (macro off).
- **Late request and `tx_enable` gating**:
  - Raise `req[1]` mid-word: no grant is issued until IDLE.
  - Drop `tx_enable` during SHIFT: the word completes (10 pulses, `word_done`), then no LOAD occurs while `tx_enable`=0 even with `req`≠0.
- **`BIT_PERIOD`=1**:
  - Shift pulses occupy cycles L+1..L+10 contiguously.
  - `word_done` at L+10.
  - `sr_load_enable` and `sr_shift_enable` never high together.
- **`HS_TX_GAP_EN` defined, `GAP_CYCLES`=2**, back-to-back requests:
  - `busy` stays high for 2 cycles after `word_done`, with both enables low.
  - LOAD-to-LOAD spacing is 44 cycles.
